// File: rtl/axi_b_resp_arb_if.sv
// Requester/B-FIFO handshake bundle for axi_b_resp_arb.
// The master side drives requests and FIFO status; the slave side is the arbiter.
interface axi_b_resp_arb_if #(
    parameter int NumReq = 4,
    parameter int W      = 7
);
    logic [NumReq-1:0]   req_valid_i;
    logic [NumReq-1:0]   req_ready_o;
    logic [NumReq*W-1:0] req_data_i;
    logic                fifo_push_o;
    logic [W-1:0]        fifo_data_o;
    logic                fifo_full_i;

    modport master (
        output req_valid_i,
        output req_data_i,
        output fifo_full_i,
        input  req_ready_o,
        input  fifo_push_o,
        input  fifo_data_o
    );

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  fifo_full_i,
        output req_ready_o,
        output fifo_push_o,
        output fifo_data_o
    );
endinterface

// File: rtl/axi_b_resp_arb.sv
// Round-robin arbiter merging per-bank B responses into one B FIFO,
// plus a write-credit counter that limits writes in flight.
module axi_b_resp_arb #(
    parameter int NumReq         = 4,
    parameter int IdWidth        = 4,
    parameter int UserWidth      = 1,
    parameter int MaxOutstanding = 8,
    localparam int W             = IdWidth + 2 + UserWidth,
    localparam int CW            = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    axi_b_resp_arb_if.slave        bus,
    input  logic                   aw_issue_i,
    input  logic                   b_done_i,
    output logic                   credit_avail_o,
    output logic [CW-1:0]          outstanding_o,
    output logic                   err_o
);
    localparam int PW = $clog2(NumReq);

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [PW-1:0] winner_s;
    logic          found_s;
    logic          push_s;
    logic          credit_s;

    // Round-robin search starting at the pointer, wrapping past NumReq-1.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            int idx;
            idx = (int'(rr_ptr_q) + i) % NumReq;
            if (!found_s && bus.req_valid_i[idx]) begin
                found_s  = 1'b1;
                winner_s = PW'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Push / grant outputs and next pointer; reset masks any grant.
    always_comb begin
        push_s          = found_s && !bus.fifo_full_i && !rst_i;
        bus.fifo_push_o = push_s;
        bus.fifo_data_o = bus.req_data_i[int'(winner_s)*W +: W];
        if (push_s) begin
            bus.req_ready_o = NumReq'(1) << winner_s;
            rr_ptr_d        = (winner_s == PW'(NumReq - 1)) ? '0 : winner_s + PW'(1);
        end else begin
            bus.req_ready_o = '0;
            rr_ptr_d        = rr_ptr_q;
        end
    end

    // Credit counter: simultaneous issue and completion cancel out.
    always_comb begin
        credit_s = (cnt_q < CW'(MaxOutstanding));
        cnt_d    = cnt_q;
        err_d    = err_q;
        case ({aw_issue_i, b_done_i})
            2'b10: begin
                if (credit_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            2'b01: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign credit_avail_o = credit_s;
    assign outstanding_o  = cnt_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_axi_b_resp_arb.sv
// Directed self-checking bench for axi_b_resp_arb (NumReq=4, MaxOutstanding=8).
module tb_axi_b_resp_arb;
    localparam int NumReq = 4;
    localparam int W      = 7;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          aw_issue;
    logic          b_done;
    logic          credit_avail;
    logic [CW-1:0] outstanding;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] dslice [NumReq] = '{7'h13, 7'h22, 7'h31, 7'h40};

    axi_b_resp_arb_if #(.NumReq(NumReq), .W(W)) bus ();

    axi_b_resp_arb #(
        .NumReq(NumReq), .IdWidth(4), .UserWidth(1), .MaxOutstanding(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .aw_issue_i(aw_issue),
        .b_done_i(b_done),
        .credit_avail_o(credit_avail),
        .outstanding_o(outstanding),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply requests at the falling edge and check the combinational grant.
    task automatic gstep(input logic [3:0] v, input logic full, input int g, input string tag);
        @(negedge clk);
        bus.req_valid_i = v;
        bus.fifo_full_i = full;
        #1;
        if (g >= 0) begin
            chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'(4'b0001 << g));
            chk({tag, "_push"}, 32'(bus.fifo_push_o), 32'd1);
            chk({tag, "_data"}, 32'(bus.fifo_data_o), 32'(dslice[g]));
        end else begin
            chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'd0);
            chk({tag, "_push"}, 32'(bus.fifo_push_o), 32'd0);
        end
    endtask

    task automatic pulse(input logic a, input logic b);
        @(negedge clk);
        aw_issue = a;
        b_done   = b;
        @(negedge clk);
        aw_issue = 1'b0;
        b_done   = 1'b0;
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        aw_issue        = 1'b0;
        b_done          = 1'b0;
        bus.req_valid_i = 4'h0;
        bus.fifo_full_i = 1'b0;
        bus.req_data_i  = {dslice[3], dslice[2], dslice[1], dslice[0]};

        repeat (2) @(negedge clk);
        bus.req_valid_i = 4'hF;
        #1;
        chk("rst_push", 32'(bus.fifo_push_o), 32'd0);
        chk("rst_rdy", 32'(bus.req_ready_o), 32'd0);

        @(negedge clk);
        rst             = 1'b0;
        bus.req_valid_i = 4'h0;
        #1;
        chk("rst_outst", 32'(outstanding), 32'd0);
        chk("rst_credit", 32'(credit_avail), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("idle_push", 32'(bus.fifo_push_o), 32'd0);

        // All requesters valid: 0,1,2,3,0 then 1 (pointer ends at 2)
        gstep(4'hF, 1'b0, 0, "rr_a0");
        gstep(4'hF, 1'b0, 1, "rr_a1");
        gstep(4'hF, 1'b0, 2, "rr_a2");
        gstep(4'hF, 1'b0, 3, "rr_a3");
        gstep(4'hF, 1'b0, 0, "rr_a4");
        gstep(4'hF, 1'b0, 1, "rr_a5");

        // Only 1 and 3 valid with pointer at 2: 3, 1, 3
        gstep(4'b1010, 1'b0, 3, "sp_3a");
        gstep(4'b1010, 1'b0, 1, "sp_1");
        gstep(4'b1010, 1'b0, 3, "sp_3b");

        // Pointer to 3, then stall five cycles, then release grants 3
        gstep(4'b0100, 1'b0, 2, "pre_full");
        for (int i = 0; i < 5; i++) gstep(4'hF, 1'b1, -1, "full");
        gstep(4'hF, 1'b0, 3, "post_full");
        gstep(4'h0, 1'b0, -1, "novalid");

        // Credits: eight issues fill the window
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b1, 1'b0);
            chk("iss_cnt", 32'(outstanding), 32'(i));
            chk("iss_credit", 32'(credit_avail), (i < 8) ? 32'd1 : 32'd0);
            chk("iss_err", 32'(err), 32'd0);
        end
        pulse(1'b1, 1'b1);
        chk("both8_cnt", 32'(outstanding), 32'd8);
        chk("both8_err", 32'(err), 32'd0);
        pulse(1'b1, 1'b0);
        chk("ninth_cnt", 32'(outstanding), 32'd8);
        chk("ninth_err", 32'(err), 32'd1);
        pulse(1'b0, 1'b1);
        chk("dec_cnt", 32'(outstanding), 32'd7);
        chk("dec_credit", 32'(credit_avail), 32'd1);
        chk("sticky_err", 32'(err), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_cnt", 32'(outstanding), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        pulse(1'b1, 1'b1);
        chk("both0_cnt", 32'(outstanding), 32'd0);
        chk("both0_err", 32'(err), 32'd0);
        pulse(1'b0, 1'b1);
        chk("under_cnt", 32'(outstanding), 32'd0);
        chk("under_err", 32'(err), 32'd1);

        // Mid-traffic reset with five writes in flight
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        chk("five_cnt", 32'(outstanding), 32'd5);
        gstep(4'hF, 1'b0, 0, "mid_0");
        gstep(4'hF, 1'b0, 1, "mid_1");
        @(negedge clk);
        rst             = 1'b1;
        bus.req_valid_i = 4'b0110;
        #1;
        chk("mid_rst_push", 32'(bus.fifo_push_o), 32'd0);
        chk("mid_rst_rdy", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_post_cnt", 32'(outstanding), 32'd0);
        chk("mid_post_err", 32'(err), 32'd0);
        chk("mid_post_rdy", 32'(bus.req_ready_o), 32'b0010);
        chk("mid_post_data", 32'(bus.fifo_data_o), 32'(dslice[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_b_resp_arb.md
AXI_B_RESP_ARB -- requirements
Module: axi_b_resp_arb

Interface
REQ-001 Parameter NumReq, default 4: number of B-response requesters (memory banks); legal range 2..16.
REQ-002 Parameter IdWidth, default 4: AXI ID width.
REQ-003 Parameter UserWidth, default 1: AXI user width.
REQ-004 Parameter MaxOutstanding, default 8: maximum writes in flight; legal range 1..255.
REQ-005 Derived W = IdWidth+2+UserWidth; packing is {id, resp[1:0], user}, MSB first; CW = $clog2(MaxOutstanding+1).
REQ-006 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_i  input  1  reset; synchronous and active-high.
REQ-008 req_valid_i  input  NumReq  per-requester B response valid.
REQ-009 req_ready_o  output  NumReq  per-requester accept.
REQ-010 req_data_i  input  NumReq*W  requester k occupies bits [k*W +: W].
REQ-011 fifo_push_o  output  1  push strobe to downstream B FIFO.
REQ-012 fifo_data_o  output  W  data for the push.
REQ-013 fifo_full_i  input  1  downstream B FIFO full.
REQ-014 aw_issue_i  input  1  one write issued to memory this cycle.
REQ-015 b_done_i  input  1  one B beat delivered to the AXI master (FIFO pop) this cycle.
REQ-016 credit_avail_o  output  1  a new write may be issued.
REQ-017 outstanding_o  output  CW  current in-flight write count.
REQ-018 err_o  output  1  sticky credit-protocol violation flag.

Function
REQ-019 The block SHALL push a response when any req_valid_i is high and fifo_full_i is low; fifo_push_o SHALL be combinational from these inputs and the current pointer.
REQ-020 Grant: round-robin; the winner is the first valid requester at or after rr_ptr_q, searching upward with wrap from NumReq-1 to 0.
REQ-021 req_ready_o SHALL be one-hot on the winner when fifo_push_o=1, and all-zero otherwise.
REQ-022 fifo_data_o SHALL equal the winner's req_data_i slice; its value is don't-care when fifo_push_o=0.
REQ-023 After each push, rr_ptr_q SHALL load (winner+1) mod NumReq; otherwise rr_ptr_q holds.
REQ-024 fifo_full_i=1 SHALL stall all requesters with no pointer change.
REQ-025 Latency: zero cycles from req_valid_i to push; a requester holding valid SHALL be granted within NumReq push cycles.
REQ-026 The counter cnt_q SHALL have CW bits; outstanding_o = cnt_q; credit_avail_o = (cnt_q < MaxOutstanding).
REQ-027 Counter update, evaluated per cycle:
- aw_issue_i only, with credit_avail_o=1: increment.
- b_done_i only, with cnt_q>0: decrement.
- Both asserted: hold, including when cnt_q=MaxOutstanding or cnt_q=0.
REQ-028 aw_issue_i alone with credit_avail_o=0 SHALL be ignored for the count and SHALL set err_o.
REQ-029 b_done_i alone with cnt_q=0 SHALL be ignored for the count and SHALL set err_o.
REQ-030 err_o, once set, SHALL remain high until reset.
REQ-031 Pushes and credit accounting are independent; no interlock between them.

Reset
REQ-032 While rst_i=1 at a clock edge: rr_ptr_q=0, cnt_q=0, err_o=0.
REQ-033 During reset, fifo_push_o and req_ready_o SHALL be forced to 0.
REQ-034 After reset, credit_avail_o=1 and outstanding_o=0.
REQ-035 Reset asserted mid-burst SHALL discard arbitration history; the first grant after reset goes to the lowest-index valid requester.

Verification (NumReq=4, MaxOutstanding=8)
REQ-036 All four requesters valid continuously, fifo_full_i=0 -> grants 0,1,2,3,0,... on consecutive cycles; fifo_data_o matches each winner's slice.
REQ-037 Only requesters 1 and 3 valid, rr_ptr_q=2 -> grant 3, then 1, then 3.
REQ-038 fifo_full_i=1 for 5 cycles with requesters valid -> no push, req_ready_o=0000, rr_ptr_q unchanged; first push after release goes to the expected requester.
REQ-039 Nine aw_issue_i pulses with no b_done_i -> outstanding_o saturates at 8, credit_avail_o=0 after the 8th, err_o=1 after the 9th.
REQ-040 At cnt_q=8, aw_issue_i and b_done_i asserted together -> count stays 8, err_o unchanged; at cnt_q=0, a lone b_done_i -> count stays 0 and err_o=1.
REQ-041 rst_i asserted for 1 cycle mid-traffic with cnt_q=5 -> next cycle outstanding_o=0, err_o=0, and the lowest valid requester is granted.
